// File: rtl/alu32_arbiter.sv
// Purpose: two-requester round-robin front end sharing one 32-bit ALU.
// Latency: request sampled at edge k -> gnt in cycle k+1 -> done in cycle k+2; one op per 3 cycles.
// Backpressure: requests are ignored while busy; a requester holds req until its gnt pulse.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req0/req1             requests, held until granted
//   a0,b0,op0 / a1,b1,op1 operands and op code of each requester
//   gnt0/gnt1             one-cycle grant pulse (operands already latched)
//   busy                  FSM not idle
//   done, done_id         one-cycle completion pulse and owner of result
//   result, c, n, z, v    registered ALU result and flags

module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        v
);
  logic [32:0] sum;

  always_comb begin
    sum = 33'd0;
    y   = 32'd0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      3'b000: y = ~a;
      3'b001: y = ~b;
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = ~(a ^ b);
      3'b110: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (y[31] != a[31]);
      end
      default: begin
        // Subtract as a + ~b + 1; carry out set means no borrow.
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        y   = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (y[31] != a[31]);
      end
    endcase
    n = y[31];
    z = (y == 32'd0);
  end
endmodule

module alu32_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [2:0]  op0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [2:0]  op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [31:0] result,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        v
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_next;
  logic        ptr;
  logic        id_q;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        any_req;
  logic        sel;
  logic [31:0] alu_y;
  logic        alu_c, alu_n, alu_z, alu_v;

  assign any_req = req0 | req1;
  // Pointer only matters on contention; a lone requester always wins.
  assign sel = (req0 & req1) ? ptr : req1;

  alu32 u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y),
    .c  (alu_c),
    .n  (alu_n),
    .z  (alu_z),
    .v  (alu_v)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      result  <= 32'd0;
      c       <= 1'b0;
      n       <= 1'b0;
      z       <= 1'b0;
      v       <= 1'b0;
      done_id <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        id_q <= sel;
        ptr  <= ~sel;
        a_q  <= sel ? a1 : a0;
        b_q  <= sel ? b1 : b0;
        op_q <= sel ? op1 : op0;
      end
      if (state == EXEC) begin
        result  <= alu_y;
        c       <= alu_c;
        n       <= alu_n;
        z       <= alu_z;
        v       <= alu_v;
        done_id <= id_q;
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (any_req) state_next = EXEC;
      EXEC: begin
        state_next = DONE;
        gnt0       = ~id_q;
        gnt1       = id_q;
      end
      DONE: begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_alu32_arbiter.sv
// Purpose: directed self-checking bench for alu32_arbiter.
// Latency: checks fixed gnt at k+1 and done at k+2 after each sampled request.
// Backpressure: exercises contention, ignored requests during EXEC and abort by reset.

module tb_alu32_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [31:0] result;
  logic        c, n, z, v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu32_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .b0      (b0),
    .op0     (op0),
    .a1      (a1),
    .b1      (b1),
    .op1     (op1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .c       (c),
    .n       (n),
    .z       (z),
    .v       (v)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation; flags packed as {c,n,z,v}.
  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] exp_res, input logic [3:0] exp_f);
    @(negedge clk);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    @(negedge clk);
    check("op_gnt0", {31'd0, gnt0}, {31'd0, ~id});
    check("op_gnt1", {31'd0, gnt1}, {31'd0, id});
    check("op_busy_exec", {31'd0, busy}, 32'd1);
    check("op_done_early", {31'd0, done}, 32'd0);
    // Drop request and scramble operands; the latched op must be unaffected.
    req0 = 1'b0; req1 = 1'b0;
    a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678; op0 = 3'd3;
    a1 = 32'hCAFE_F00D; b1 = 32'h8765_4321; op1 = 3'd4;
    @(negedge clk);
    check("op_done", {31'd0, done}, 32'd1);
    check("op_gnt_in_done", {30'd0, gnt1, gnt0}, 32'd0);
    check("op_result", result, exp_res);
    check("op_flags", {28'd0, c, n, z, v}, {28'd0, exp_f});
    check("op_done_id", {31'd0, done_id}, {31'd0, id});
    @(negedge clk);
    check("op_done_clr", {31'd0, done}, 32'd0);
    check("op_busy_idle", {31'd0, busy}, 32'd0);
    check("op_result_hold", result, exp_res);
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 32'd0; b0 = 32'd0; op0 = 3'd0;
    a1 = 32'd0; b1 = 32'd0; op1 = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_done_id", {31'd0, done_id}, 32'd0);
    check("rst_flags", {28'd0, c, n, z, v}, 32'd0);
    check("rst_result", result, 32'd0);
    reset_n = 1'b1;

    // Directed vectors; flags are {c,n,z,v}.
    do_op(1'b0, 32'h0000_1010, 32'h0000_0110, 3'b010, 32'h0000_0010, 4'b0000);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0000, 4'b1010);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 4'b1010);
    do_op(1'b0, 32'h0001_000F, 32'h0000_0001, 3'b111, 32'h0001_000E, 4'b1000);
    do_op(1'b1, 32'h0F0F_0000, 32'h0000_0000, 3'b000, 32'hF0F0_FFFF, 4'b0100);
    do_op(1'b0, 32'h1234_0000, 32'hFFFF_FFFF, 3'b001, 32'h0000_0000, 4'b0010);
    do_op(1'b1, 32'h00FF_00FF, 32'h0000_FF00, 3'b011, 32'h00FF_FFFF, 4'b0000);
    do_op(1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 3'b100, 32'h5555_5555, 4'b0000);
    do_op(1'b1, 32'h1234_5678, 32'h1234_5678, 3'b101, 32'hFFFF_FFFF, 4'b0100);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b110, 32'h8000_0000, 4'b0101);
    do_op(1'b1, 32'h8000_0000, 32'h0000_0001, 3'b111, 32'h7FFF_FFFF, 4'b1001);

    // Contention: both requests held from reset; pointer starts at 0.
    @(negedge clk);
    reset_n = 1'b0;
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 3'b110;
    req1 = 1'b1; a1 = 32'd5; b1 = 32'd3; op1 = 3'b111;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_gnt1", {31'd0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
      check("cont_done", {31'd0, done}, 32'd1);
      check("cont_done_id", {31'd0, done_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("cont_result", result, (i % 2 == 1) ? 32'd2 : 32'd8);
      @(negedge clk);
      check("cont_idle", {31'd0, busy}, 32'd0);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end

    // Ignored request: req1 rises during requester 0's EXEC.
    @(negedge clk);
    req0 = 1'b1; a0 = 32'h0000_00F0; b0 = 32'h0000_003C; op0 = 3'b010;
    @(negedge clk);
    check("ign_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b1; a1 = 32'h0000_0100; b1 = 32'h0000_0023; op1 = 3'b011;
    @(negedge clk);
    check("ign_gnt1_done", {31'd0, gnt1}, 32'd0);
    check("ign_result0", result, 32'h0000_0030);
    check("ign_done_id0", {31'd0, done_id}, 32'd0);
    @(negedge clk);
    check("ign_gnt1_idle", {31'd0, gnt1}, 32'd0);
    check("ign_busy_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("ign_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    check("ign_result1", result, 32'h0000_0123);
    check("ign_done_id1", {31'd0, done_id}, 32'd1);
    @(negedge clk);

    // Abort: reset in the EXEC cycle.
    @(negedge clk);
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd1; op0 = 3'b110;
    @(negedge clk);
    check("abt_gnt0", {31'd0, gnt0}, 32'd1);
    reset_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check("abt_done", {31'd0, done}, 32'd0);
    check("abt_busy", {31'd0, busy}, 32'd0);
    check("abt_result", result, 32'd0);
    check("abt_done_id", {31'd0, done_id}, 32'd0);
    reset_n = 1'b1;
    do_op(1'b0, 32'd7, 32'd1, 3'b110, 32'd8, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
